// File: rtl/sd_iq_frame_buffer.sv
// Ping-pong frame buffer: packs parsed SD IQ words into FRAME_LEN-sample frames and streams them out.
// R_IDLE: wait for rd_bank full | R_FETCH: first RAM read | R_STREAM: present samples, prefetch on handshake
module sd_iq_frame_buffer #(
  parameter int FRAME_LEN = 128,
  parameter int ADDR_W    = $clog2(FRAME_LEN),
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      sd_data,
  input  logic             sd_data_valid,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_i,
  output logic [15:0]      m_q,
  output logic             m_last,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       bank_full
);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  logic [31:0] mem [0:(2**(ADDR_W+1))-1];

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              last_q, last_d;
  logic [31:0]       data_q;
  logic              wr_en, rd_en, release_bank, wr_bank_free;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_full_d  = bank_full_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    last_d       = last_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;

    release_bank = (state_q == R_STREAM) && m_ready && last_q;
    // A bank released this cycle is immediately writable again.
    wr_bank_free = !bank_full_q[wr_bank_q] || (release_bank && (rd_bank_q == wr_bank_q));

    if (flush) begin
      wr_addr_d = '0;
    end else if (sd_data_valid) begin
      if (wr_bank_free) begin
        wr_en = 1'b1;
        if (wr_addr_q == LAST_ADDR) begin
          wr_addr_d    = '0;
          wr_bank_d    = ~wr_bank_q;
          frame_done_d = 1'b1;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      R_IDLE: begin
        if (bank_full_q[rd_bank_q]) state_d = R_FETCH;
      end
      R_FETCH: begin
        rd_en     = 1'b1;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        last_d    = (rd_addr_q == LAST_ADDR);
        state_d   = R_STREAM;
      end
      R_STREAM: begin
        if (m_ready) begin
          if (last_q) begin
            rd_bank_d   = ~rd_bank_q;
            rd_addr_d   = '0;
            last_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = bank_full_q[~rd_bank_q] ? R_FETCH : R_IDLE;
          end else begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            last_d    = (rd_addr_q == LAST_ADDR);
          end
        end
      end
      default: state_d = R_IDLE;
    endcase

    if (release_bank) bank_full_d[rd_bank_q] = 1'b0;
    if (frame_done_d) bank_full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= R_IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      bank_full_q  <= 2'b00;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_full_q  <= bank_full_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      last_q       <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_q, wr_addr_q}] <= sd_data;
  end

  // RAM read register doubles as the output register; it only advances on fetch/handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (rd_en) begin
      data_q <= mem[{rd_bank_q, rd_addr_q}];
    end
  end

  assign m_valid    = (state_q == R_STREAM);
  assign m_i        = data_q[31:16];
  assign m_q        = data_q[15:0];
  assign m_last     = last_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign bank_full  = bank_full_q;

endmodule

// File: tb/tb_sd_iq_frame_buffer.sv
// Directed bench for sd_iq_frame_buffer: frame ordering, drops, stalls, flush, gaps and reset abort.
module tb_sd_iq_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sd_data;
  logic        sd_data_valid;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_i;
  logic [15:0] m_q;
  logic        m_last;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [1:0]  bank_full;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  logic [32:0] rx_q[$];
  logic [32:0] exp_q[$];

  sd_iq_frame_buffer dut (
    .clk(clk), .rst(rst), .sd_data(sd_data), .sd_data_valid(sd_data_valid), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q), .m_last(m_last),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(input int v);
    logic [15:0] iv;
    iv = v[15:0];
    return {iv, -iv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input bit expect_out, input bit rnd_ready);
    for (int k = 1; k <= 128; k++) begin
      sd_data       = mk_word(base + k);
      sd_data_valid = 1'b1;
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      if (expect_out) exp_q.push_back({(k == 128), mk_word(base + k)});
      tick();
    end
    sd_data_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input bit rnd_ready);
    int n = 0;
    while (frame_cnt != 16'(target) && n < budget) begin
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check_val("frame_cnt_wait", frame_cnt, target);
  endtask

  task automatic compare_rx(input string tag);
    int n;
    check_val({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_val({tag, "_sample"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  // Accepted-sample capture and output stability while stalled.
  logic        stall_prev = 1'b0;
  logic [32:0] held = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check_val("hold_valid", m_valid, 1);
        check_val("hold_data", {m_last, m_i, m_q}, held);
      end
      if (m_valid && m_ready) rx_q.push_back({m_last, m_i, m_q});
      if (frame_done) fd_cnt++;
    end
    stall_prev = !rst && m_valid && !m_ready;
    held       = {m_last, m_i, m_q};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    int gaps;
    int n;
    rst = 1'b1; sd_data = '0; sd_data_valid = 1'b0; flush = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    check_val("rst_valid", m_valid, 0);
    check_val("rst_last", m_last, 0);
    check_val("rst_fdone", frame_done, 0);
    check_val("rst_i", m_i, 0);
    check_val("rst_q", m_q, 0);
    check_val("rst_fcnt", frame_cnt, 0);
    check_val("rst_dcnt", drop_cnt, 0);
    check_val("rst_bfull", bank_full, 0);
    rst = 1'b0;
    tick();

    // Single frame, always ready
    m_ready = 1'b1;
    fd0 = fd_cnt;
    send_frame(0, 1, 0);
    wait_frames(1, 400, 0);
    check_val("t1_fdone", fd_cnt - fd0, 1);
    compare_rx("t1");

    // Three frames with downstream stalled: third is dropped
    m_ready = 1'b0;
    fd0 = fd_cnt;
    send_frame(32'h1000, 1, 0);
    send_frame(32'h2000, 1, 0);
    send_frame(32'h3000, 0, 0);
    repeat (2) tick();
    check_val("t2_bfull", bank_full, 2'b11);
    check_val("t2_drop", drop_cnt, 128);
    check_val("t2_fdone", fd_cnt - fd0, 2);
    check_val("t2_stall_valid", m_valid, 1);
    m_ready = 1'b1;
    wait_frames(3, 700, 0);
    compare_rx("t2");
    check_val("t2_bfull_after", bank_full, 2'b00);

    // Random backpressure
    fd0 = fd_cnt;
    send_frame(32'h4000, 1, 1);
    wait_frames(4, 1000, 1);
    m_ready = 1'b1;
    tick();
    check_val("t3_fdone", fd_cnt - fd0, 1);
    compare_rx("t3");

    // Partial frame, flush with coincident word, then a full frame
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
    m_ready = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      sd_data = mk_word(32'h5000 + k);
      sd_data_valid = 1'b1;
      tick();
    end
    sd_data = 32'hDEAD_BEEF;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sd_data_valid = 1'b0;
    send_frame(32'h6000, 1, 0);
    wait_frames(1, 400, 0);
    check_val("t4_drop", drop_cnt, 0);
    compare_rx("t4");

    // Both banks full, then drain: exactly one idle cycle between frames
    m_ready = 1'b0;
    send_frame(32'h7000, 1, 0);
    send_frame(32'h7100, 1, 0);
    tick();
    check_val("t5_bfull", bank_full, 2'b11);
    m_ready = 1'b1;
    gaps = 0;
    n = 0;
    while (frame_cnt != 16'd3 && n < 700) begin
      tick();
      n++;
      if (frame_cnt != 16'd3 && !m_valid) gaps++;
    end
    check_val("t5_fcnt", frame_cnt, 3);
    check_val("t5_gap", gaps, 1);
    compare_rx("t5");

    // Reset mid-frame aborts delivery
    m_ready = 1'b0;
    send_frame(32'h8000, 0, 0);
    m_ready = 1'b1;
    repeat (10) tick();
    check_val("t6_pre_valid", m_valid, 1);
    rst = 1'b1;
    tick();
    check_val("t6_valid", m_valid, 0);
    check_val("t6_i", m_i, 0);
    check_val("t6_q", m_q, 0);
    check_val("t6_last", m_last, 0);
    check_val("t6_fcnt", frame_cnt, 0);
    check_val("t6_dcnt", drop_cnt, 0);
    check_val("t6_bfull", bank_full, 0);
    check_val("t6_fdone", frame_done, 0);
    rst = 1'b0;
    tick();
    rx_q.delete();
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
